spinet: RTL and testbench

- Packet network of N SPI-slave ports (nodes) joined by an internal unidirectional slot ring; sits in the user project area, with each node's SPI pins routed to GPIO.
- Host on node k writes a 16-bit packet addressed to node j. The ring carries it to j, raises rxrdy[j], and j's host reads it in a later SPI transaction.
- SPI is full duplex: every 16-bit transaction shifts one packet in and one packet out.

---
 rtl/spinet_pkg.sv | 28 ++
 rtl/spinet_node.sv | 123 ++++++++++++
 rtl/spinet.sv | 47 ++++
 tb/tb_spinet.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spinet_pkg.sv
// spinet shared types: 16-bit ring packet layout and field positions.
// Optional build macro SPINET_SRC_STAMP_EN is consumed by spinet_node.
package spinet_pkg;

    localparam int PKT_W      = 16;
    localparam int ADDR_W     = 3;
    localparam int VALID_BIT  = 15;
    localparam int RSVD_BIT   = 14;
    localparam int DST_HI     = 13;
    localparam int DST_LO     = 11;
    localparam int SRC_HI     = 10;
    localparam int SRC_LO     = 8;
    localparam int PAYLOAD_HI = 7;
    localparam int PAYLOAD_LO = 0;

    typedef struct packed {
        logic              valid;
        logic              rsvd;
        logic [ADDR_W-1:0] dst;
        logic [ADDR_W-1:0] src;
        logic [7:0]        payload;
    } pkt_t;

    function automatic logic dst_ok(input pkt_t p, input int n);
        return int'(p.dst) < n;
    endfunction

endpackage

// File: rtl/spinet_node.sv
// spinet_node: one SPI slave port with tx/rx buffers and ring tap.
// SPINET_SRC_STAMP_EN: overwrite source field with own address on accept.
module spinet_node
    import spinet_pkg::*;
#(
    parameter int N    = 6,
    parameter int ADDR = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic miso,
    output logic txrdy,
    output logic rxrdy,
    input  pkt_t slot_in,
    output pkt_t slot_out
);

    localparam logic [ADDR_W-1:0] MY = ADDR_W'(ADDR);

    logic [2:0]       sck_s;
    logic [2:0]       ss_s;
    logic [1:0]       mosi_s;
    logic [PKT_W-1:0] sr_in;
    logic [PKT_W-1:0] sr_out;
    logic [4:0]       cnt;
    logic             rd_pend;
    pkt_t             txbuf;
    pkt_t             rxbuf;
    logic             tx_full;
    logic             rx_full;

    logic sck_rise, sck_fall, ss_fall, ss_rise, active, done;
    logic rx_take, inject, drop;
    pkt_t after, tx_new;

    assign sck_rise = sck_s[1] & ~sck_s[2];
    assign sck_fall = ~sck_s[1] & sck_s[2];
    assign ss_fall  = ~ss_s[1] & ss_s[2];
    assign ss_rise  = ss_s[1] & ~ss_s[2];
    assign active   = ~ss_s[1];
    assign done     = ss_rise && (cnt == 5'd16);

    // gate with the raw pin so miso releases as soon as ss goes high
    assign miso  = ~ss & active & sr_out[PKT_W-1];
    assign txrdy = ~tx_full;
    assign rxrdy = rx_full;

    always_comb begin
        rx_take  = slot_in.valid && (slot_in.dst == MY) && !rx_full;
        after    = rx_take ? '0 : slot_in;
        drop     = tx_full && !dst_ok(txbuf, N);
        inject   = tx_full && dst_ok(txbuf, N) && !after.valid;
        slot_out = inject ? txbuf : after;
        tx_new   = pkt_t'(sr_in);
`ifdef SPINET_SRC_STAMP_EN
        tx_new.src = MY;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s  <= 3'b000;
            ss_s   <= 3'b111;
            mosi_s <= 2'b00;
        end else begin
            sck_s  <= {sck_s[1:0], sck};
            ss_s   <= {ss_s[1:0], ss};
            mosi_s <= {mosi_s[0], mosi};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_in   <= '0;
            sr_out  <= '0;
            cnt     <= '0;
            rd_pend <= 1'b0;
        end else if (ss_fall) begin
            sr_out  <= rx_full ? PKT_W'(rxbuf) : '0;
            cnt     <= '0;
            rd_pend <= rx_full;
        end else if (active) begin
            if (sck_rise) begin
                sr_in <= {sr_in[PKT_W-2:0], mosi_s[1]};
                // saturate past 16 so over-clocked transfers still abort
                cnt   <= (cnt == 5'd17) ? cnt : cnt + 5'd1;
            end
            if (sck_fall) begin
                sr_out <= {sr_out[PKT_W-2:0], 1'b0};
            end
        end else if (ss_rise) begin
            rd_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_full <= 1'b0;
            txbuf   <= '0;
        end else if (inject || drop) begin
            tx_full <= 1'b0;
        end else if (done && sr_in[VALID_BIT] && !tx_full) begin
            tx_full <= 1'b1;
            txbuf   <= tx_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_full <= 1'b0;
            rxbuf   <= '0;
        end else if (rx_take) begin
            rx_full <= 1'b1;
            rxbuf   <= slot_in;
        end else if (done && rd_pend) begin
            rx_full <= 1'b0;
        end
    end

endmodule

// File: rtl/spinet.sv
// spinet: N SPI-slave nodes joined by a unidirectional slot ring.
// Build with SPINET_SRC_STAMP_EN to stamp source addresses on accept.
module spinet
    import spinet_pkg::*;
#(
    parameter int N = 6
) (
    input  logic         wb_clk_i,
    input  logic         rst_n,
    input  logic [N-1:0] spi_sck,
    input  logic [N-1:0] spi_ss,
    input  logic [N-1:0] spi_mosi,
    output logic [N-1:0] spi_miso,
    output logic [N-1:0] txrdy,
    output logic [N-1:0] rxrdy
);

    pkt_t slot_q [N];
    pkt_t slot_d [N];

    for (genvar k = 0; k < N; k++) begin : g_node
        spinet_node #(
            .N    (N),
            .ADDR (k)
        ) u_node (
            .clk      (wb_clk_i),
            .rst_n    (rst_n),
            .sck      (spi_sck[k]),
            .ss       (spi_ss[k]),
            .mosi     (spi_mosi[k]),
            .miso     (spi_miso[k]),
            .txrdy    (txrdy[k]),
            .rxrdy    (rxrdy[k]),
            .slot_in  (slot_q[(k + N - 1) % N]),
            .slot_out (slot_d[k])
        );
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) slot_q[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) slot_q[k] <= slot_d[k];
        end
    end

endmodule

// File: tb/tb_spinet.sv
// tb_spinet: directed scenarios plus random traffic against a
// transaction-level model of buffers and circulating packets.
module tb_spinet;

    localparam int N = 6;
`ifdef SPINET_SRC_STAMP_EN
    localparam bit STAMP = 1'b1;
`else
    localparam bit STAMP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] sck, ss, mosi, miso, txrdy, rxrdy;

    int checks = 0;
    int errors = 0;

    spinet #(.N(N)) dut (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .spi_sck  (sck),
        .spi_ss   (ss),
        .spi_mosi (mosi),
        .spi_miso (miso),
        .txrdy    (txrdy),
        .rxrdy    (rxrdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // mode-0 host: miso sampled just before each rising sck
    task automatic xfer(input int n, input logic [15:0] w, input int nb,
                        output logic [15:0] r);
        r = '0;
        ss[n] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            mosi[n] = (i < 16) ? w[15-i] : 1'b0;
            tick(4);
            r = {r[14:0], miso[n]};
            sck[n] = 1'b1;
            tick(4);
            sck[n] = 1'b0;
        end
        tick(4);
        ss[n] = 1'b1;
        mosi[n] = 1'b0;
    endtask

    function automatic logic [15:0] stamp(input logic [15:0] w, input int n);
        logic [15:0] s;
        s = w;
        if (STAMP) s[10:8] = 3'(n);
        return s;
    endfunction

    logic [15:0] r;
    logic [15:0] rx_d [N];
    logic [15:0] pend_d [N];
    bit          rx_v [N];
    bit          pend_v [N];
    int          npend;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        sck = '0;
        ss = '1;
        mosi = '0;
        tick(3);
        check("rst_txrdy", 16'(txrdy), 16'h3F);
        check("rst_rxrdy", 16'(rxrdy), 16'h0);
        check("rst_miso", 16'(miso), 16'h0);
        rst_n = 1'b1;
        tick(4);

        // basic delivery node0 -> node1
        xfer(0, 16'h8841, 16, r);
        check("basic_rd0", r, 16'h0000);
        lat = 0;
        while (!rxrdy[1] && lat < N + 8) begin
            tick(1);
            lat++;
        end
        check("basic_rxrdy", 16'(rxrdy[1]), 16'h1);
        tick(4);
        xfer(1, 16'h0000, 16, r);
        check("basic_read", r, stamp(16'h8841, 0));
        tick(4);
        check("basic_rxclr", 16'(rxrdy), 16'h0);

        // empty poll
        xfer(3, 16'h0000, 16, r);
        check("poll_word", r, 16'h0000);
        tick(4);
        check("poll_rxrdy", 16'(rxrdy), 16'h0);
        check("poll_txrdy", 16'(txrdy), 16'h3F);

        // aborted read keeps the packet
        xfer(0, 16'h8841, 16, r);
        tick(14);
        check("abort_pre", 16'(rxrdy[1]), 16'h1);
        xfer(1, 16'h0000, 8, r);
        tick(6);
        check("abort_keep", 16'(rxrdy[1]), 16'h1);
        xfer(1, 16'h0000, 16, r);
        check("abort_read", r, stamp(16'h8841, 0));
        tick(4);
        check("abort_clr", 16'(rxrdy[1]), 16'h0);

        // source stamping (identity without the option)
        xfer(3, 16'h8755, 16, r);
        tick(3 * N + 12);
        xfer(0, 16'h0000, 16, r);
        check("stamp_read", r, stamp(16'h8755, 3));
        tick(4);

        // fill rx5 and the whole ring, then overfill node0 tx
        for (int i = 0; i < N + 1; i++) begin
            xfer(0, 16'hA800 | 16'(i), 16, r);
            tick(3 * N + 12);
        end
        check("full_txrdy", 16'(txrdy), 16'h3F);
        xfer(0, 16'h9077, 16, r);
        tick(3 * N + 12);
        check("full_hold", 16'(txrdy[0]), 16'h0);
        xfer(0, 16'h9888, 16, r);
        tick(3 * N + 12);
        check("full_hold2", 16'(txrdy[0]), 16'h0);
        xfer(5, 16'h0000, 16, r);
        check("full_rd5", r, stamp(16'hA800, 0));
        tick(3 * N + 12);
        check("full_inj", 16'(txrdy[0]), 16'h1);
        check("full_rx2", 16'(rxrdy[2]), 16'h1);
        xfer(2, 16'h0000, 16, r);
        check("full_rd2", r, stamp(16'h9077, 0));
        for (int i = 0; i < N; i++) begin
            tick(3 * N + 12);
            xfer(5, 16'h0000, 16, r);
            check("full_drain", 16'(r[15:8]), 16'hA8);
        end
        tick(3 * N + 12);
        check("full_lost", 16'(rxrdy), 16'h0);

        // reset during a transaction and with a packet in flight
        ss[2] = 1'b0;
        tick(4);
        sck[2] = 1'b1;
        tick(4);
        sck[2] = 1'b0;
        xfer(0, 16'hA811, 16, r);
        tick(5);
        rst_n = 1'b0;
        tick(1);
        check("mid_txrdy", 16'(txrdy), 16'h3F);
        check("mid_rxrdy", 16'(rxrdy), 16'h0);
        check("mid_miso", 16'(miso), 16'h0);
        ss[2] = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(40);
        check("mid_nodeliv", 16'(rxrdy), 16'h0);
        check("mid_txrdy2", 16'(txrdy), 16'h3F);

        // random traffic
        for (int j = 0; j < N; j++) begin
            rx_v[j] = 0;
            pend_v[j] = 0;
        end
        npend = 0;
        for (int op = 0; op < 40; op++) begin
            int n, d;
            bit promoted;
            logic [15:0] w, exp_r, exp_rx;
            n = int'($urandom_range(N - 1));
            exp_r = rx_v[n] ? rx_d[n] : 16'h0000;
            promoted = 0;
            if (rx_v[n]) begin
                rx_v[n] = 0;
                if (pend_v[n]) begin
                    rx_v[n] = 1;
                    rx_d[n] = pend_d[n];
                    pend_v[n] = 0;
                    npend--;
                    promoted = 1;
                end
            end
            d = int'($urandom_range(7));
            w = {2'b10, 3'(d), 3'($urandom), 8'($urandom)};
            if (($urandom % 4) == 0 || promoted) w = 16'h0000;
            if (d < N && (pend_v[d] || (rx_v[d] && npend >= 3)))
                w = 16'h0000;
            if (w[15] && d < N) begin
                if (!rx_v[d]) begin
                    rx_v[d] = 1;
                    rx_d[d] = stamp(w, n);
                end else begin
                    pend_v[d] = 1;
                    pend_d[d] = stamp(w, n);
                    npend++;
                end
            end
            xfer(n, w, 16, r);
            check("rnd_miso", r, exp_r);
            tick(3 * N + 12);
            exp_rx = '0;
            for (int j = 0; j < N; j++) exp_rx[j] = rx_v[j];
            check("rnd_txrdy", 16'(txrdy), 16'h3F);
            check("rnd_rxrdy", 16'(rxrdy), exp_rx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
